// File: rtl/d_ff_using_jk.sv
// -----------------------------------------------------------------------------
// d_ff_using_jk
//
// A D-type register built from JK flip-flop cores. Each bit has its own
// D-to-JK excitation logic (J = d, K = ~d) that drives a complete JK core
// (hold / reset / set / toggle). With this excitation only the set and reset
// cases occur, so every rising edge gives q <= d. The hold and toggle cases
// stay in the core so it remains a faithful JK primitive.
//
// Parameters:
//   WIDTH  number of independent bits (default 1)
//
// Ports (positional order is fixed: d, clk, rst, q, qb):
//   d    in   [WIDTH-1:0]  data input, sampled on the rising edge of clk
//   clk  in   1            rising-edge clock
//   rst  in   1            synchronous reset, active-high; clears q to 0
//   q    out  [WIDTH-1:0]  registered data
//   qb   out  [WIDTH-1:0]  complement of q
// -----------------------------------------------------------------------------
module d_ff_using_jk #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    // D-to-JK excitation. J and K are always complementary.
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    assign j = d;
    assign k = ~d;

    // One JK core per bit; bits share nothing but clk and rst.
    for (genvar i = 0; i < WIDTH; i++) begin : g_jk_core
        always_ff @(posedge clk) begin
            // Reset is tested first so an unknown d cannot reach q.
            if (rst) begin
                q[i] <= 1'b0;
            end else begin
                case ({j[i], k[i]})
                    2'b00:   q[i] <= q[i];
                    2'b01:   q[i] <= 1'b0;
                    2'b10:   q[i] <= 1'b1;
                    2'b11:   q[i] <= ~q[i];
                    default: q[i] <= q[i];
                endcase
            end
        end
    end

    // Complement derived combinationally so it can never disagree with q.
    assign qb = ~q;

endmodule

// File: tb/tb_d_ff_using_jk.sv
// -----------------------------------------------------------------------------
// tb_d_ff_using_jk
//
// Self-checking bench for d_ff_using_jk with WIDTH=4. Inputs change on the
// falling edge; outputs are sampled 1 time unit after the rising edge and
// just before it. The reference model is the register's defining rule:
// after each rising edge, q equals 0 when rst was high, otherwise the d
// sampled at that edge.
// -----------------------------------------------------------------------------
module tb_d_ff_using_jk;

    localparam int W = 4;
    localparam logic [W-1:0] ALL1 = '1;

    logic         clk;
    logic         rst;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] qb;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    logic [W-1:0] model_q;

    d_ff_using_jk #(.WIDTH(W)) dut (
        .d   (d),
        .clk (clk),
        .rst (rst),
        .q   (q),
        .qb  (qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Drive one cycle: apply inputs away from the edge, confirm q has not
    // moved before the edge, then check q/qb after the edge.
    task automatic step(input string tag, input logic rst_v,
                        input logic [W-1:0] d_v);
        @(negedge clk);
        rst = rst_v;
        d   = d_v;
        #4;
        check({tag, "_hold"}, q, model_q);
        @(posedge clk);
        model_q = rst_v ? '0 : d_v;
        #1;
        check({tag, "_q"}, q, model_q);
        check({tag, "_qb"}, qb, ~model_q);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic r;
        logic [W-1:0] dv;

        // Reset with unknown data at the first edge (t=5).
        rst = 1'b1;
        d   = 'x;
        @(posedge clk);
        #1;
        model_q = '0;
        check("rst_x_q", q, '0);
        check("rst_x_qb", qb, ALL1);

        // Release reset with d=0, then capture a 1.
        step("rel_d0", 1'b0, 4'h0);
        step("cap1", 1'b0, 4'h1);

        // Alternate data each cycle.
        step("alt_a", 1'b0, 4'hF);
        step("alt_b", 1'b0, 4'h0);
        step("alt_c", 1'b0, 4'hF);
        step("alt_d", 1'b0, 4'h0);
        step("alt_e", 1'b0, 4'h5);
        step("alt_f", 1'b0, 4'hA);

        // Synchronous reset mid-run, then release with d all ones.
        step("pre_rst", 1'b0, 4'hF);
        step("mid_rst", 1'b1, 4'hF);
        step("post_rst", 1'b0, 4'hF);

        // Reset dominates unknown data mid-run as well.
        step("rst_dx", 1'b1, 'x);

        // Glitch between edges must not be captured.
        @(negedge clk);
        rst = 1'b0;
        d   = 4'hF;
        #2;
        d   = 4'h0;
        #2;
        check("glitch_hold", q, model_q);
        @(posedge clk);
        model_q = 4'h0;
        #1;
        check("glitch_q", q, 4'h0);
        check("glitch_qb", qb, ALL1);

        step("cap_a", 1'b0, 4'hA);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 300; i++) begin
            r  = ($urandom_range(0, 7) == 0);
            dv = W'($urandom);
            step("rand", r, dv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_cnt, fail_cnt);
        $finish;
    end

endmodule
